// File: rtl/bus_sched_if.sv
// Bus scheduler signal bundle: four requesters with their source codes on one
// side, the registered read-mux select / grant / valid / busy on the other.
interface bus_sched_if;
   logic [3:0] req;
   logic [2:0] src0;
   logic [2:0] src1;
   logic [2:0] src2;
   logic [2:0] src3;
   logic [2:0] select;
   logic [3:0] grant;
   logic       valid;
   logic       busy;

   // Requester side drives requests and source codes.
   modport master (
      output req, src0, src1, src2, src3,
      input  select, grant, valid, busy
   );

   // Scheduler side answers with the registered mux control.
   modport slave (
      input  req, src0, src1, src2, src3,
      output select, grant, valid, busy
   );
endinterface

// File: rtl/bus_sched.sv
// Round-robin scheduler for a 16-bit read mux with four requesters.
// A grant latches the winner's source code. RAM (code 111) may need RAM_WAIT
// extra cycles before its data is valid. Each XFER cycle re-arbitrates with
// the current owner masked, so transfers to different requesters run
// back-to-back.
module bus_sched #(
   parameter int RAM_WAIT = 1   // legal range 0..3
) (
   input  logic        clk,
   input  logic        rst,
   bus_sched_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_XFER = 2'd2
   } state_t;

   localparam logic [2:0] SRC_RAM   = 3'b111;
   localparam logic [1:0] WAIT_INIT = 2'(RAM_WAIT);

   state_t     r_state;
   logic [1:0] r_cnt;
   logic [1:0] r_last;
   logic [3:0] r_grant;
   logic [2:0] r_select;
   logic       r_valid;

   state_t     w_state_next;
   logic [1:0] w_cnt_next;
   logic [1:0] w_last_next;
   logic [3:0] w_grant_next;
   logic [2:0] w_select_next;
   logic       w_valid_next;

   logic [11:0] w_src_flat;
   logic [2:0]  w_src [4];
   logic [3:0]  w_cand;
   logic        w_win_any;
   logic [1:0]  w_win_idx;
   logic        w_win_ram;

   assign w_src_flat = {bus.src3, bus.src2, bus.src1, bus.src0};

   // Unpack the per-requester source codes so they can be indexed by winner.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_src
         assign w_src[gi] = w_src_flat[gi*3 +: 3];
      end
   endgenerate

   // In XFER the current owner is masked so another requester can take over.
   assign w_cand = (r_state == S_XFER) ? (bus.req & ~r_grant) : bus.req;

   // Rotating priority search starting at last+1. The loop runs from the
   // lowest priority (last itself) to the highest (last+1), so the final
   // hit that is written is the true winner.
   always_comb begin
      w_win_any = 1'b0;
      w_win_idx = r_last;
      for (int k = 4; k >= 1; k--) begin
         if (w_cand[r_last + 2'(k)]) begin
            w_win_any = 1'b1;
            w_win_idx = r_last + 2'(k);
         end
      end
   end

   assign w_win_ram = (w_src[w_win_idx] == SRC_RAM) && (RAM_WAIT > 0);

   // State register: all scheduler state, cleared by synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= 2'd0;
         r_last   <= 2'b11;
         r_grant  <= 4'b0000;
         r_select <= 3'b000;
         r_valid  <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_cnt    <= w_cnt_next;
         r_last   <= w_last_next;
         r_grant  <= w_grant_next;
         r_select <= w_select_next;
         r_valid  <= w_valid_next;
      end
   end

   // Next-state logic: arbitrate from IDLE/XFER, count down RAM wait cycles.
   always_comb begin
      w_state_next  = r_state;
      w_cnt_next    = r_cnt;
      w_last_next   = r_last;
      w_grant_next  = r_grant;
      w_select_next = r_select;
      w_valid_next  = 1'b0;
      case (r_state)
         S_IDLE, S_XFER: begin
            if (w_win_any) begin
               w_grant_next  = 4'b0001 << w_win_idx;
               w_select_next = w_src[w_win_idx];
               w_last_next   = w_win_idx;
               if (w_win_ram) begin
                  w_state_next = S_WAIT;
                  w_cnt_next   = WAIT_INIT;
               end else begin
                  w_state_next = S_XFER;
                  w_cnt_next   = 2'd0;
                  w_valid_next = 1'b1;
               end
            end else begin
               w_state_next  = S_IDLE;
               w_cnt_next    = 2'd0;
               w_grant_next  = 4'b0000;
               w_select_next = 3'b000;
            end
         end
         S_WAIT: begin
            // grant and select stay frozen while the RAM data settles.
            if (r_cnt == 2'd1) begin
               w_state_next = S_XFER;
               w_cnt_next   = 2'd0;
               w_valid_next = 1'b1;
            end else begin
               w_cnt_next = r_cnt - 2'd1;
            end
         end
         default: begin
            w_state_next  = S_IDLE;
            w_cnt_next    = 2'd0;
            w_grant_next  = 4'b0000;
            w_select_next = 3'b000;
         end
      endcase
   end

   // Output logic: registered mux control plus busy decoded from state.
   always_comb begin
      bus.grant  = r_grant;
      bus.select = r_select;
      bus.valid  = r_valid;
      bus.busy   = (r_state != S_IDLE);
   end

endmodule

// File: tb/tb_bus_sched.sv
// Self-checking bench for bus_sched: three instances (RAM_WAIT = 1, 0, 3)
// driven from one vector table through a scoreboard queue, then a random
// invariant run and a bounded RAM-latency measurement.
module tb_bus_sched;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   bus_sched_if if_a ();
   bus_sched_if if_b ();
   bus_sched_if if_c ();

   bus_sched #(.RAM_WAIT(1)) u_dut_a (.clk(clk), .rst(rst), .bus(if_a));
   bus_sched #(.RAM_WAIT(0)) u_dut_b (.clk(clk), .rst(rst), .bus(if_b));
   bus_sched #(.RAM_WAIT(3)) u_dut_c (.clk(clk), .rst(rst), .bus(if_c));

   // inst: 0 = RAM_WAIT 1, 1 = RAM_WAIT 0, 2 = RAM_WAIT 3
   typedef struct {
      int              inst;
      logic            rst;
      logic [3:0]      req;
      logic [3:0][2:0] src;
      logic [3:0]      grant;
      logic [2:0]      select;
      logic            valid;
      logic            busy;
   } vec_t;

   typedef struct {
      int         inst;
      int         idx;
      logic [8:0] exp;
   } sb_t;

   vec_t vecs[$];
   sb_t  sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic vec_t mk(int inst, logic r, logic [3:0] req,
                               logic [3:0][2:0] src, logic [3:0] g,
                               logic [2:0] s, logic v, logic b);
      vec_t t;
      t.inst = inst; t.rst = r; t.req = req; t.src = src;
      t.grant = g; t.select = s; t.valid = v; t.busy = b;
      return t;
   endfunction

   function automatic logic [8:0] outs(int inst);
      case (inst)
         0:       return {if_a.grant, if_a.select, if_a.valid, if_a.busy};
         1:       return {if_b.grant, if_b.select, if_b.valid, if_b.busy};
         default: return {if_c.grant, if_c.select, if_c.valid, if_c.busy};
      endcase
   endfunction

   task automatic drive(int inst, logic [3:0] req, logic [3:0][2:0] src);
      if_a.req = 4'b0; if_b.req = 4'b0; if_c.req = 4'b0;
      case (inst)
         0: begin
            if_a.req = req;
            if_a.src0 = src[0]; if_a.src1 = src[1]; if_a.src2 = src[2]; if_a.src3 = src[3];
         end
         1: begin
            if_b.req = req;
            if_b.src0 = src[0]; if_b.src1 = src[1]; if_b.src2 = src[2]; if_b.src3 = src[3];
         end
         default: begin
            if_c.req = req;
            if_c.src0 = src[0]; if_c.src1 = src[1]; if_c.src2 = src[2]; if_c.src3 = src[3];
         end
      endcase
   endtask

   task automatic check(string name, logic [8:0] act, logic [8:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got grant=%b select=%b valid=%b busy=%b, expected grant=%b select=%b valid=%b busy=%b",
                  name, act[8:5], act[4:2], act[1], act[0], exp[8:5], exp[4:2], exp[1], exp[0]);
      end else begin
         $display("ok   %s: grant=%b select=%b valid=%b busy=%b",
                  name, act[8:5], act[4:2], act[1], act[0]);
      end
   endtask

   task automatic check_bit(string name, logic act, logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   localparam logic [3:0][2:0] S0   = {3'o0, 3'o0, 3'o0, 3'o0};
   localparam logic [3:0][2:0] S23  = {3'o0, 3'o0, 3'o0, 3'o2};  // src0 = PC
   localparam logic [3:0][2:0] SR2  = {3'o0, 3'o7, 3'o0, 3'o0};  // src2 = RAM
   localparam logic [3:0][2:0] SRR  = {3'o5, 3'o3, 3'o1, 3'o0};  // 000,001,011,101
   localparam logic [3:0][2:0] SMX  = {3'o0, 3'o0, 3'o2, 3'o7};  // src0 RAM, src1 PC
   localparam logic [3:0][2:0] SIR3 = {3'o6, 3'o0, 3'o0, 3'o0};  // src3 = IR
   localparam logic [3:0][2:0] SR1  = {3'o0, 3'o0, 3'o7, 3'o0};  // src1 = RAM
   localparam logic [3:0][2:0] SR3  = {3'o7, 3'o0, 3'o0, 3'o0};  // src3 = RAM

   initial begin
      drive(0, 4'b0, S0); drive(1, 4'b0, S0); drive(2, 4'b0, S0);

      // reset ignores requests; single register read
      vecs.push_back(mk(0, 1, 4'b1111, SRR, 4'b0000, 3'o0, 0, 0));
      vecs.push_back(mk(0, 0, 4'b0000, S0,  4'b0000, 3'o0, 0, 0));
      vecs.push_back(mk(0, 0, 4'b0001, S23, 4'b0001, 3'o2, 1, 1));
      vecs.push_back(mk(0, 0, 4'b0000, S23, 4'b0000, 3'o0, 0, 0));
      // RAM with one wait cycle; src change after grant is ignored
      vecs.push_back(mk(0, 0, 4'b0100, SR2, 4'b0100, 3'o7, 0, 1));
      vecs.push_back(mk(0, 0, 4'b0000, S0,  4'b0100, 3'o7, 1, 1));
      vecs.push_back(mk(0, 0, 4'b0000, S0,  4'b0000, 3'o0, 0, 0));
      // RAM with no wait
      vecs.push_back(mk(1, 0, 4'b0100, SR2, 4'b0100, 3'o7, 1, 1));
      vecs.push_back(mk(1, 0, 4'b0000, S0,  4'b0000, 3'o0, 0, 0));
      // round-robin over four persistent requesters
      vecs.push_back(mk(0, 1, 4'b0000, S0,  4'b0000, 3'o0, 0, 0));
      vecs.push_back(mk(0, 0, 4'b1111, SRR, 4'b0001, 3'o0, 1, 1));
      vecs.push_back(mk(0, 0, 4'b1111, SRR, 4'b0010, 3'o1, 1, 1));
      vecs.push_back(mk(0, 0, 4'b1111, SRR, 4'b0100, 3'o3, 1, 1));
      vecs.push_back(mk(0, 0, 4'b1111, SRR, 4'b1000, 3'o5, 1, 1));
      vecs.push_back(mk(0, 0, 4'b1111, SRR, 4'b0001, 3'o0, 1, 1));
      vecs.push_back(mk(0, 0, 4'b0000, SRR, 4'b0000, 3'o0, 0, 0));
      // RAM and register requesters interleaved
      vecs.push_back(mk(0, 1, 4'b0000, S0,  4'b0000, 3'o0, 0, 0));
      vecs.push_back(mk(0, 0, 4'b0011, SMX, 4'b0001, 3'o7, 0, 1));
      vecs.push_back(mk(0, 0, 4'b0011, SMX, 4'b0001, 3'o7, 1, 1));
      vecs.push_back(mk(0, 0, 4'b0011, SMX, 4'b0010, 3'o2, 1, 1));
      vecs.push_back(mk(0, 0, 4'b0011, SMX, 4'b0001, 3'o7, 0, 1));
      vecs.push_back(mk(0, 0, 4'b0000, SMX, 4'b0001, 3'o7, 1, 1));
      vecs.push_back(mk(0, 0, 4'b0000, SMX, 4'b0000, 3'o0, 0, 0));
      // lone persistent requester alternates with idle
      vecs.push_back(mk(0, 0, 4'b1000, SIR3, 4'b1000, 3'o6, 1, 1));
      vecs.push_back(mk(0, 0, 4'b1000, SIR3, 4'b0000, 3'o0, 0, 0));
      vecs.push_back(mk(0, 0, 4'b1000, SIR3, 4'b1000, 3'o6, 1, 1));
      vecs.push_back(mk(0, 0, 4'b1000, SIR3, 4'b0000, 3'o0, 0, 0));
      vecs.push_back(mk(0, 0, 4'b0000, SIR3, 4'b0000, 3'o0, 0, 0));
      // reset mid-WAIT with RAM_WAIT 3
      vecs.push_back(mk(2, 1, 4'b0000, S0,  4'b0000, 3'o0, 0, 0));
      vecs.push_back(mk(2, 0, 4'b0010, SR1, 4'b0010, 3'o7, 0, 1));
      vecs.push_back(mk(2, 1, 4'b1111, SR1, 4'b0000, 3'o0, 0, 0));
      vecs.push_back(mk(2, 0, 4'b0000, S0,  4'b0000, 3'o0, 0, 0));
      vecs.push_back(mk(2, 0, 4'b1111, S0,  4'b0001, 3'o0, 1, 1));
      vecs.push_back(mk(2, 0, 4'b0000, S0,  4'b0000, 3'o0, 0, 0));
      // full three-cycle RAM wait
      vecs.push_back(mk(2, 0, 4'b1000, SR3, 4'b1000, 3'o7, 0, 1));
      vecs.push_back(mk(2, 0, 4'b0000, S0,  4'b1000, 3'o7, 0, 1));
      vecs.push_back(mk(2, 0, 4'b0000, S0,  4'b1000, 3'o7, 0, 1));
      vecs.push_back(mk(2, 0, 4'b0000, S0,  4'b1000, 3'o7, 1, 1));
      vecs.push_back(mk(2, 0, 4'b0000, S0,  4'b0000, 3'o0, 0, 0));

      // Table: drive, push expectation, sample #1 after the edge, pop, compare.
      for (int i = 0; i < vecs.size(); i++) begin
         sb_t e;
         rst = vecs[i].rst;
         drive(vecs[i].inst, vecs[i].req, vecs[i].src);
         e.inst = vecs[i].inst;
         e.idx  = i;
         e.exp  = {vecs[i].grant, vecs[i].select, vecs[i].valid, vecs[i].busy};
         sb_q.push_back(e);
         @(posedge clk);
         #1;
         begin
            sb_t got;
            got = sb_q.pop_front();
            check($sformatf("vec%0d/inst%0d", got.idx, got.inst), outs(got.inst), got.exp);
         end
      end

      // Random traffic on the RAM_WAIT=1 instance: grant one-hot or zero,
      // valid only with a grant, busy exactly when something is granted.
      rst = 1'b0;
      for (int c = 0; c < 150; c++) begin
         logic [3:0] g;
         logic       ok;
         if_a.req  = 4'($urandom_range(0, 15));
         if_a.src0 = 3'($urandom_range(0, 7));
         if_a.src1 = 3'($urandom_range(0, 7));
         if_a.src2 = 3'($urandom_range(0, 7));
         if_a.src3 = 3'($urandom_range(0, 7));
         @(posedge clk);
         #1;
         g  = if_a.grant;
         ok = ($countones(g) <= 1) && !(if_a.valid && g == 4'b0) && (if_a.busy == (g != 4'b0));
         check_bit($sformatf("invariant cycle %0d", c), ok, 1'b1);
      end

      // RAM latency on the RAM_WAIT=1 instance, bounded wait for valid.
      if_a.req = 4'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      if_a.req  = 4'b0100;
      if_a.src2 = 3'o7;
      begin
         int cycles;
         cycles = 0;
         do begin
            @(posedge clk); #1;
            if_a.req = 4'b0;
            cycles++;
         end while (!if_a.valid && cycles < 10);
         check_bit("ram latency valid seen", if_a.valid, 1'b1);
         n_checks++;
         if (cycles != 2) begin
            n_fail++;
            $display("FAIL ram latency: got %0d cycles, expected 2", cycles);
         end else begin
            $display("ok   ram latency: %0d cycles", cycles);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/bus_sched.md
BUS_SCHED -- requirements
Module: bus_sched

Interface
REQ-001 Parameter: RAM_WAIT, default 1, number of wait cycles inserted before data from source code 3'b111 (RAM) is valid; legal range 0..3.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req  input  4  per-requester transfer request; req[i] belongs to requester i.
REQ-005 src0, src1, src2, src3  input  3 each  source code wanted by requester i: 000 AC, 001 AR, 010 PC, 011 DR, 100 TR, 101 R, 110 IR, 111 RAM.
REQ-006 select  output  3  registered source select driven to the 16-bit read mux.
REQ-007 grant  output  4  registered one-hot grant; all zero when idle.
REQ-008 valid  output  1  registered; high for exactly one cycle per transfer, when the mux output carries the granted source's data.
REQ-009 busy  output  1  high whenever state is not IDLE.

Function
REQ-010 The block SHALL implement three states: IDLE, WAIT and XFER.
REQ-011 The block SHALL keep a 2-bit last-winner pointer `last`; arbitration is round-robin, searching from requester (last+1) mod 4 upward with wrap-around.
REQ-012 IDLE, any req bit high at an edge: grant <= one-hot(winner); select <= src of winner; last <= winner.
- If src is 111 and RAM_WAIT > 0: go to WAIT, wait counter <= RAM_WAIT, valid <= 0.
- Otherwise: go to XFER, valid <= 1.
REQ-013 IDLE, req = 0: outputs hold their idle values (grant 0, select 000, valid 0, busy 0).
REQ-014 WAIT: the counter decrements by 1 each cycle.
- Edge at which counter = 1: go to XFER, valid <= 1.
- grant and select are held unchanged throughout WAIT.
REQ-015 XFER, valid high for this cycle: the block SHALL re-arbitrate at the next edge over (req & ~grant).
- The current owner is masked, so a lone persistent requester gets an idle cycle between its transfers.
- If a winner exists: apply REQ-012 directly (back-to-back transfers with no idle gap).
- If no winner: go to IDLE with grant 0, select 000, valid 0.
REQ-016 src inputs are sampled only at the grant edge; a later change to src SHALL NOT alter select for the transfer in progress.
REQ-017 Deasserting req after grant SHALL NOT abort the transfer; it completes with its valid pulse.
REQ-018 Latency: a register-source request seen at edge N gives grant and valid high in cycle N+1. A RAM request gives grant from cycle N+1 and valid in cycle N+1+RAM_WAIT.
REQ-019 grant SHALL always be zero or exactly one-hot; valid SHALL never be high while grant is zero.
REQ-020 Simultaneous requests SHALL be resolved only by the REQ-011 pointer; each requester continuously requesting is served within 4 transfers.

Reset
REQ-021 rst high at an edge, in any state including mid-WAIT or mid-XFER, SHALL force:
- state IDLE, grant 0000, select 000, valid 0, busy 0;
- wait counter 0, last 2'b11, so requester 0 has top priority after reset.
REQ-022 A transfer interrupted by reset SHALL produce no valid pulse, and req sampled during reset SHALL be ignored.

Verification
REQ-023 Single register read: after reset, req=0001 with src0=010 for one edge -> next cycle grant=0001, select=010, valid=1, busy=1; the following cycle grant=0000, valid=0, busy=0.
REQ-024 RAM wait with RAM_WAIT=1: req=0100, src2=111 -> cycle 1 grant=0100, select=111, valid=0; cycle 2 valid=1; cycle 3 idle. Same stimulus with RAM_WAIT=0 -> valid in cycle 1.
REQ-025 Round-robin, all four requesters held high with srcs 000, 001, 011, 101 -> grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles; select follows 000, 001, 011, 101, 000; valid high every cycle.
REQ-026 Lone persistent requester: req=1000 held, src3=110 -> grant pattern 1000, 0000, 1000, 0000; valid only in the granted cycles.
REQ-027 Reset mid-WAIT with RAM_WAIT=3: rst asserted the cycle after a RAM grant -> next cycle all outputs 0 and no valid pulse. Then req=1111 -> grant=0001.
